spfs_bus_arbiter: RTL and testbench

Round-robin arbiter for the single-bit SPI flash (SPFS) pad group: the `cust_spfs_clk/cs/mosi/miso` pads. It shares those pads between `NUM_REQ` SPI-master requesters, such as the boot loader, the XIP engine and the DMA. It grants whole transactions, inserts a chip-select guard interval between owners, and revokes a grant held past a timeout. It sits between the requester SPI masters and the SPFS pad cells inside `retrosoc_asic`.

---
 rtl/spfs_bus_arbiter.sv | 104 ++++++++++
 tb/tb_spfs_bus_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/spfs_bus_arbiter.sv
// spfs_bus_arbiter: round-robin owner arbitration of the SPFS pads with guard interval and grant timeout
module spfs_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int GUARD_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  input  logic [NUM_REQ-1:0] req_clk_i,
  input  logic [NUM_REQ-1:0] req_cs_i,
  input  logic [NUM_REQ-1:0] req_mosi_i,
  output logic [NUM_REQ-1:0] req_miso_o,
  output logic               spfs_clk_o,
  output logic               spfs_cs_o,
  output logic               spfs_mosi_o,
  input  logic               spfs_miso_i,
  output logic [NUM_REQ-1:0] to_err_o,
  input  logic               err_clr_i,
  output logic               busy_o
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GW = GUARD_CYCLES > 1 ? $clog2(GUARD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;
  state_t state, state_nx;
  logic [PW-1:0] owner, owner_nx, rr_ptr, rr_nx, pick, owner_inc;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [GW-1:0] gcnt, gcnt_nx;
  logic [NUM_REQ-1:0] gnt_nx, blk, elig, sel, tset;
  logic found, rel, expire;
  assign elig = req_i & ~blk;
  assign sel = NUM_REQ'(1) << owner;
  assign owner_inc = owner == PW'(NUM_REQ - 1) ? '0 : owner + PW'(1);
  assign rel = !req_i[owner];
  assign expire = TIMEOUT_CYCLES != 0 && |gnt_o && tcnt == TW'(TIMEOUT_CYCLES);
  assign spfs_clk_o = |gnt_o && req_clk_i[owner];
  assign spfs_cs_o = |gnt_o ? req_cs_i[owner] : 1'b1;
  assign spfs_mosi_o = |gnt_o && req_mosi_i[owner];
  assign req_miso_o = gnt_o & {NUM_REQ{spfs_miso_i}};
  always_comb begin
    pick = rr_ptr;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (elig[(int'(rr_ptr) + i) % NUM_REQ]) begin
        pick = PW'((int'(rr_ptr) + i) % NUM_REQ);
        found = 1'b1;
      end
  end
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    rr_nx = rr_ptr;
    gnt_nx = gnt_o;
    tcnt_nx = tcnt;
    gcnt_nx = gcnt;
    tset = '0;
    case (state)
      IDLE: if (found) begin
        state_nx = GRANT;
        owner_nx = pick;
      end
      GRANT: if (rel || expire) begin
        state_nx = GUARD;
        gnt_nx = '0;
        gcnt_nx = '0;
        rr_nx = owner_inc;
        tset = rel ? '0 : sel;
      end else if (!(|gnt_o)) begin
        gnt_nx = sel;
        tcnt_nx = TW'(1);
      end else if (tcnt != '1) begin
        tcnt_nx = tcnt + TW'(1);
      end
      GUARD: if (gcnt == GW'(GUARD_CYCLES - 1)) state_nx = IDLE;
        else gcnt_nx = gcnt + GW'(1);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      gnt_o <= '0;
      tcnt <= '0;
      gcnt <= '0;
      blk <= '0;
      to_err_o <= '0;
      busy_o <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      rr_ptr <= rr_nx;
      gnt_o <= gnt_nx;
      tcnt <= tcnt_nx;
      gcnt <= gcnt_nx;
      blk <= (blk & req_i) | tset;
      to_err_o <= (err_clr_i ? '0 : to_err_o) | tset;
      busy_o <= state_nx != IDLE;
    end
  end
endmodule

// File: tb/tb_spfs_bus_arbiter.sv
// tb_spfs_bus_arbiter: cycle-keyed scoreboard bench for spfs_bus_arbiter
module tb_spfs_bus_arbiter;
  localparam logic [9:0] M_ALL = 10'h3ff, M_BUSY = 10'h200, M_ERR = 10'h180, M_GNT = 10'h060,
    M_MISO = 10'h018, M_CS = 10'h002, M_PAD = 10'h007;
  typedef struct {string tag; int at; logic [9:0] mask; logic [9:0] val;} exp_t;
  logic clk = 0, rst = 1, clr = 0, smiso = 0, sclk, scs, smosi, busy;
  logic [1:0] req = 0, rclk = 0, rcs = 2'b11, rmosi = 0, gnt, miso, err;
  logic [9:0] obs;
  exp_t q[$];
  exp_t cur;
  int cyc = 0, total = 0, bad = 0, b, s, o, g;
  spfs_bus_arbiter #(.NUM_REQ(2), .GUARD_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .req_clk_i(rclk), .req_cs_i(rcs),
    .req_mosi_i(rmosi), .req_miso_o(miso), .spfs_clk_o(sclk), .spfs_cs_o(scs), .spfs_mosi_o(smosi),
    .spfs_miso_i(smiso), .to_err_o(err), .err_clr_i(clr), .busy_o(busy)
  );
  assign obs = {busy, err, gnt, miso, sclk, scs, smosi};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [9:0] pk(input int bz, e, gn, m, c, cs, mo);
    return {bz[0], e[1:0], gn[1:0], m[1:0], c[0], cs[0], mo[0]};
  endfunction
  task automatic ex(input string tag, input int at, input logic [9:0] mask, input logic [9:0] val);
    q.push_back('{tag, at, mask, val});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic goto(input int t);
    while (cyc < t) step();
  endtask
  task automatic do_reset();
    rst = 1;
    req = 0;
    clr = 0;
    step();
    rst = 0;
  endtask
  always @(negedge clk)
    while (q.size() > 0 && q[0].at <= cyc) begin
      cur = q.pop_front();
      total++;
      if (cur.at != cyc) begin
        bad++;
        $display("FAIL %s: cycle %0d never sampled (now %0d)", cur.tag, cur.at, cyc);
      end else if ((obs & cur.mask) !== (cur.val & cur.mask)) begin
        bad++;
        $display("FAIL %s @%0d: got %b want %b mask %b", cur.tag, cyc, obs & cur.mask, cur.val & cur.mask, cur.mask);
      end
    end
  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    b = cyc;
    rclk = 2'b01; rcs = 2'b10; rmosi = 2'b01; smiso = 1;
    ex("t1_reset", b, M_ALL, pk(0, 0, 0, 0, 0, 1, 0));
    ex("t1_wait", b + 1, M_ALL, pk(1, 0, 0, 0, 0, 1, 0));
    ex("t1_grant", b + 2, M_ALL, pk(1, 0, 1, 1, 1, 0, 1));
    ex("t1_pinmove", b + 5, M_PAD | M_GNT, pk(0, 0, 1, 0, 0, 0, 0));
    ex("t1_pinback", b + 8, M_PAD, pk(0, 0, 0, 0, 1, 0, 1));
    ex("t1_last", b + 11, M_GNT, pk(0, 0, 1, 0, 0, 0, 0));
    ex("t1_release", b + 12, M_ALL, pk(1, 0, 0, 0, 0, 1, 0));
    ex("t1_guard", b + 15, M_BUSY | M_CS, pk(1, 0, 0, 0, 0, 1, 0));
    ex("t1_idle", b + 16, M_BUSY, pk(0, 0, 0, 0, 0, 0, 0));
    req = 2'b01;
    goto(b + 5); rclk[0] = 0; rmosi[0] = 0;
    goto(b + 8); rclk[0] = 1; rmosi[0] = 1;
    goto(b + 11); req = 0;
    goto(b + 17);
    do_reset();
    b = cyc;
    rclk = 2'b01; rmosi = 2'b10; rcs = 2'b00; smiso = 1;
    for (int k = 0; k < 4; k++) begin
      s = b + 2 + 14 * k; o = k % 2; g = o ? 2 : 1;
      ex("t2_prelow", s - 1, M_GNT | M_CS, pk(0, 0, 0, 0, 0, 1, 0));
      ex("t2_grant", s, M_GNT | M_MISO | M_PAD, pk(0, 0, g, g, 1 - o, 0, o));
      ex("t2_release", s + 8, M_GNT | M_MISO | M_PAD, pk(0, 0, 0, 0, 0, 1, 0));
      ex("t2_guard", s + 11, M_CS | M_BUSY, pk(1, 0, 0, 0, 0, 1, 0));
    end
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      s = b + 2 + 14 * k; o = k % 2;
      goto(s + 7); req[o] = 0;
      goto(s + 8); req[o] = 1;
    end
    goto(b + 56);
    do_reset();
    b = cyc;
    rcs = 2'b11; rclk = 0; rmosi = 0;
    ex("t3_first", b + 2, M_GNT, pk(0, 0, 1, 0, 0, 0, 0));
    ex("t3_last", b + 17, M_GNT | M_ERR, pk(0, 0, 1, 0, 0, 0, 0));
    ex("t3_expire", b + 18, M_GNT | M_ERR | M_CS, pk(0, 1, 0, 0, 0, 1, 0));
    ex("t3_next", b + 24, M_GNT | M_ERR, pk(0, 1, 2, 0, 0, 0, 0));
    ex("t3_blocked", b + 34, M_GNT | M_BUSY, pk(0, 0, 0, 0, 0, 0, 0));
    ex("t3_dropped", b + 41, M_GNT | M_BUSY, pk(0, 0, 0, 0, 0, 0, 0));
    ex("t3_rewait", b + 42, M_GNT | M_BUSY, pk(1, 0, 0, 0, 0, 0, 0));
    ex("t3_regrant", b + 43, M_GNT | M_ERR, pk(0, 1, 1, 0, 0, 0, 0));
    req = 2'b11;
    goto(b + 27); req[1] = 0;
    goto(b + 40); req[0] = 0;
    goto(b + 41); req[0] = 1;
    goto(b + 44); req = 0;
    do_reset();
    b = cyc;
    ex("t4_last", b + 17, M_GNT | M_ERR, pk(0, 0, 1, 0, 0, 0, 0));
    ex("t4_release", b + 18, M_GNT | M_ERR | M_BUSY, pk(1, 0, 0, 0, 0, 0, 0));
    ex("t4_wait", b + 23, M_GNT | M_BUSY, pk(1, 0, 0, 0, 0, 0, 0));
    ex("t4_regrant", b + 24, M_GNT | M_ERR, pk(0, 0, 1, 0, 0, 0, 0));
    req = 2'b01;
    goto(b + 17); req = 0;
    goto(b + 18); req = 2'b01;
    goto(b + 25); req = 0;
    do_reset();
    b = cyc;
    ex("t5_expire", b + 18, M_GNT | M_ERR, pk(0, 2, 0, 0, 0, 0, 0));
    ex("t5_sticky", b + 20, M_ERR, pk(0, 2, 0, 0, 0, 0, 0));
    ex("t5_clear", b + 21, M_ERR, pk(0, 0, 0, 0, 0, 0, 0));
    ex("t5_last", b + 39, M_GNT | M_ERR, pk(0, 0, 1, 0, 0, 0, 0));
    ex("t5_setwins", b + 40, M_GNT | M_ERR, pk(0, 1, 0, 0, 0, 0, 0));
    req = 2'b10;
    goto(b + 18); req = 0;
    goto(b + 20); clr = 1;
    goto(b + 21); clr = 0; req = 2'b01;
    goto(b + 39); clr = 1;
    goto(b + 40); clr = 0; req = 0;
    goto(b + 41);
    do_reset();
    b = cyc;
    rclk = 2'b11; rmosi = 2'b11; rcs = 2'b00; smiso = 1;
    ex("t6_first", b + 3, M_GNT, pk(0, 0, 1, 0, 0, 0, 0));
    ex("t6_owner1", b + 10, M_GNT, pk(0, 0, 2, 0, 0, 0, 0));
    ex("t6_pre_rst", b + 12, M_GNT | M_CS | M_BUSY, pk(1, 0, 2, 0, 0, 0, 0));
    ex("t6_post_rst", b + 13, M_ALL, pk(0, 0, 0, 0, 0, 1, 0));
    ex("t6_wait", b + 14, M_GNT | M_BUSY, pk(1, 0, 0, 0, 0, 0, 0));
    ex("t6_rr_reset", b + 15, M_GNT, pk(0, 0, 1, 0, 0, 0, 0));
    req = 2'b01;
    goto(b + 3); req = 0;
    goto(b + 4); req = 2'b11;
    goto(b + 12); rst = 1;
    goto(b + 13); rst = 0;
    goto(b + 16); req = 0;
    goto(b + 18);
    if (q.size() > 0) begin
      $display("FAIL leftover: %0d expectations unchecked, want 0", q.size());
      total += q.size();
      bad += q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
